// File: rtl/addsub_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_seq_if
// Description : Operand/result handshake bundle for addsub_seq.
//               Producer side: in_valid/in_ready, sub, x, y, cin.
//               Consumer side: out_valid/out_ready, z, cout, ovf, zero.
//               slave  modport : the adder/subtractor itself.
//               master modport : whoever drives operands and takes results.
// Revision    : 1.0 - initial release
// ============================================================================
interface addsub_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic             sub;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, sub, x, y, cin, out_ready,
    input  in_ready, out_valid, z, cout, ovf, zero
  );

  modport slave (
    input  in_valid, sub, x, y, cin, out_ready,
    output in_ready, out_valid, z, cout, ovf, zero
  );
endinterface
`default_nettype wire

// File: rtl/addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : addsub_seq
// Description : Multi-cycle adder/subtractor, SLICE bits per clock with a
//               registered carry between slices. Computes x + y + cin or
//               x - y - cin over WIDTH/SLICE cycles and reports carry/borrow,
//               signed overflow and zero flags.
// Ports       : clk   - rising-edge clock
//               rst_n - asynchronous active-low reset
//               flush - synchronous abort back to IDLE (highest priority)
//               bus   - addsub_seq_if.slave operand/result handshakes
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  wire         clk,
  input  wire         rst_n,
  input  wire         flush,
  addsub_seq_if.slave bus
);

  localparam int NSTEP = WIDTH / SLICE;
  localparam int KW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] xa_q, xa_d;
  logic [WIDTH-1:0] ya_q, ya_d;    // y, already inverted for subtract
  logic             sub_q, sub_d;
  logic             c_q, c_d;      // carry between slices
  logic [KW-1:0]    k_q, k_d;      // current slice index
  logic [WIDTH-1:0] z_q, z_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  // Slice datapath
  logic [31:0]      base_w;
  logic [SLICE-1:0] xs_w;
  logic [SLICE-1:0] ys_w;
  logic [SLICE:0]   sum_w;
  logic             cmsb_w;

  assign base_w = 32'(k_q) * 32'(SLICE);
  assign xs_w   = xa_q[base_w +: SLICE];
  assign ys_w   = ya_q[base_w +: SLICE];
  assign sum_w  = {1'b0, xs_w} + {1'b0, ys_w} + {{SLICE{1'b0}}, c_q};
  // Carry into the top bit of the slice, recovered from the sum bit: on the
  // last slice this is the carry into bit WIDTH-1 used for signed overflow.
  assign cmsb_w = xs_w[SLICE-1] ^ ys_w[SLICE-1] ^ sum_w[SLICE-1];

  always_comb begin
    state_d = state_q;
    xa_d    = xa_q;
    ya_d    = ya_q;
    sub_d   = sub_q;
    c_d     = c_q;
    k_d     = k_q;
    z_d     = z_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          // Subtract is x + ~y + ~cin, so borrow-in becomes an inverted carry.
          xa_d    = bus.x;
          ya_d    = bus.sub ? ~bus.y : bus.y;
          sub_d   = bus.sub;
          c_d     = bus.cin ^ bus.sub;
          k_d     = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        z_d[base_w +: SLICE] = sum_w[SLICE-1:0];
        c_d = sum_w[SLICE];
        if (k_q == KW'(NSTEP - 1)) begin
          cout_d  = sum_w[SLICE] ^ sub_q;   // borrow is the inverted carry
          ovf_d   = sum_w[SLICE] ^ cmsb_w;
          zero_d  = (z_d == '0);
          k_d     = '0;
          state_d = ST_DONE;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      xa_q    <= '0;
      ya_q    <= '0;
      sub_q   <= 1'b0;
      c_q     <= 1'b0;
      k_q     <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xa_q    <= xa_d;
      ya_q    <= ya_d;
      sub_q   <= sub_d;
      c_q     <= c_d;
      k_q     <= k_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.z         = z_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_seq
// Description : Self-checking bench for addsub_seq. Instantiates five
//               configurations (WIDTH,SLICE) = (32,8) (32,1) (32,32) (16,4)
//               (8,8) and checks them against an integer-arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addsub_seq;

  localparam int NCFG = 5;

  function automatic int cfg_w(input int i);
    case (i)
      0, 1, 2: return 32;
      3:       return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int cfg_s(input int i);
    case (i)
      0:       return 8;
      1:       return 1;
      2:       return 32;
      3:       return 4;
      default: return 8;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fl_a   [NCFG];
  logic        iv_a   [NCFG];
  logic        sub_a  [NCFG];
  logic        cin_a  [NCFG];
  logic        ordy_a [NCFG];
  logic [31:0] x_a    [NCFG];
  logic [31:0] y_a    [NCFG];
  logic        ir_a   [NCFG];
  logic        ov_a   [NCFG];
  logic        co_a   [NCFG];
  logic        of_a   [NCFG];
  logic        zr_a   [NCFG];
  logic [31:0] z_a    [NCFG];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int W = cfg_w(g);
    localparam int S = cfg_s(g);
    addsub_seq_if #(.WIDTH(W)) bus ();
    assign bus.in_valid  = iv_a[g];
    assign bus.sub       = sub_a[g];
    assign bus.x         = x_a[g][W-1:0];
    assign bus.y         = y_a[g][W-1:0];
    assign bus.cin       = cin_a[g];
    assign bus.out_ready = ordy_a[g];
    assign ir_a[g]       = bus.in_ready;
    assign ov_a[g]       = bus.out_valid;
    assign z_a[g]        = 32'(bus.z);
    assign co_a[g]       = bus.cout;
    assign of_a[g]       = bus.ovf;
    assign zr_a[g]       = bus.zero;
    addsub_seq #(.WIDTH(W), .SLICE(S)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (fl_a[g]),
      .bus   (bus.slave)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic on w-bit operands.
  function automatic void ref_model(input int w, input bit s, input logic [31:0] xv,
                                    input logic [31:0] yv, input bit ci,
                                    output logic [31:0] ez, output bit eco,
                                    output bit eov, output bit ezr);
    longint mask, half, ux, uy, sx, sy, ru, rs;
    mask = (longint'(1) <<< w) - 1;
    half = longint'(1) <<< (w - 1);
    ux = longint'(xv) & mask;
    uy = longint'(yv) & mask;
    sx = (ux >= half) ? ux - 2 * half : ux;
    sy = (uy >= half) ? uy - 2 * half : uy;
    if (!s) begin
      ru  = ux + uy + longint'(ci);
      rs  = sx + sy + longint'(ci);
      eco = (ru > mask);
    end else begin
      ru  = ux - uy - longint'(ci);
      rs  = sx - sy - longint'(ci);
      eco = (ru < 0);
    end
    ez  = 32'(ru & mask);
    eov = (rs >= half) || (rs < -half);
    ezr = (ez == 32'd0);
  endfunction

  // Entered and left at a falling edge.
  task automatic run_op(input int c, input bit s, input logic [31:0] xv, input logic [31:0] yv,
                        input bit ci, input bit consume, input string tag);
    int w, ns, guard, lat;
    logic [31:0] ez;
    bit eco, eov, ezr;
    w  = cfg_w(c);
    ns = w / cfg_s(c);
    ref_model(w, s, xv, yv, ci, ez, eco, eov, ezr);
    guard = 0;
    while (ir_a[c] !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    sub_a[c] = s; x_a[c] = xv; y_a[c] = yv; cin_a[c] = ci; iv_a[c] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_a[c] = 1'b0; x_a[c] = $urandom; y_a[c] = $urandom; cin_a[c] = 1'($urandom);
    lat = 0;
    while (ov_a[c] !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, " latency"}, lat, ns);
    check({tag, " z"}, z_a[c], ez);
    check({tag, " cout"}, 32'(co_a[c]), 32'(eco));
    check({tag, " ovf"}, 32'(of_a[c]), 32'(eov));
    check({tag, " zero"}, 32'(zr_a[c]), 32'(ezr));
    if (consume) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin : main
    bit seen;
    logic [31:0] rx, ry;

    for (int c = 0; c < NCFG; c++) begin
      fl_a[c] = 1'b0; iv_a[c] = 1'b0; sub_a[c] = 1'b0; cin_a[c] = 1'b0;
      ordy_a[c] = 1'b1; x_a[c] = '0; y_a[c] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state, every configuration
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("rst c%0d in_ready", c), 32'(ir_a[c]), 32'd1);
      check($sformatf("rst c%0d out_valid", c), 32'(ov_a[c]), 32'd0);
      check($sformatf("rst c%0d z", c), z_a[c], 32'd0);
      check($sformatf("rst c%0d flags", c), {29'd0, co_a[c], of_a[c], zr_a[c]}, 32'd0);
    end
    rst_n = 1'b1;

    // Directed arithmetic cases, WIDTH=32 SLICE=8
    run_op(0, 1'b1, 32'd5, 32'd3, 1'b0, 1'b1, "sub 5-3");
    run_op(0, 1'b1, 32'd3, 32'd5, 1'b0, 1'b1, "sub 3-5");
    run_op(0, 1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1, "sub ovf");
    run_op(0, 1'b0, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b1, "add ovf");
    run_op(0, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, "add wrap");
    run_op(0, 1'b0, 32'd1, 32'd1, 1'b1, 1'b1, "add cin");
    run_op(0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b1, "sub bin");
    run_op(0, 1'b0, 32'h00FF_FFFF, 32'd1, 1'b0, 1'b1, "carry chain");

    // Backpressure: result held while out_ready is low, offers ignored
    ordy_a[0] = 1'b0;
    run_op(0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      iv_a[0] = 1'(i); x_a[0] = $urandom; y_a[0] = $urandom;
      @(posedge clk);
      @(negedge clk);
      check("bp out_valid", 32'(ov_a[0]), 32'd1);
      check("bp in_ready", 32'(ir_a[0]), 32'd0);
      check("bp z", z_a[0], 32'h2345_6789);
      check("bp flags", {29'd0, co_a[0], of_a[0], zr_a[0]}, 32'd0);
    end
    iv_a[0] = 1'b0;
    ordy_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp release out_valid", 32'(ov_a[0]), 32'd0);
    check("bp release in_ready", 32'(ir_a[0]), 32'd1);

    // Flush while slice 2 is being computed
    sub_a[0] = 1'b0; x_a[0] = 32'h0101_0101; y_a[0] = 32'h0202_0202; cin_a[0] = 1'b0;
    iv_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_a[0] = 1'b0;
    check("run in_ready", 32'(ir_a[0]), 32'd0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    fl_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    fl_a[0] = 1'b0;
    check("flush in_ready", 32'(ir_a[0]), 32'd1);
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | ov_a[0];
    end
    check("flush no out_valid", 32'(seen), 32'd0);
    run_op(0, 1'b1, 32'hDEAD_BEEF, 32'h0000_BEEF, 1'b0, 1'b1, "after flush");

    // Asynchronous reset mid-RUN
    sub_a[0] = 1'b0; x_a[0] = 32'h1111_1111; y_a[0] = 32'h2222_2222; cin_a[0] = 1'b0;
    iv_a[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv_a[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst run in_ready", 32'(ir_a[0]), 32'd1);
    check("rst run out_valid", 32'(ov_a[0]), 32'd0);
    check("rst run z", z_a[0], 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Asynchronous reset mid-DONE
    ordy_a[0] = 1'b0;
    run_op(0, 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, "pre rst done");
    #1 rst_n = 1'b0;
    #1;
    check("rst done out_valid", 32'(ov_a[0]), 32'd0);
    check("rst done flags", {29'd0, co_a[0], of_a[0], zr_a[0]}, 32'd0);
    ordy_a[0] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    run_op(0, 1'b0, 32'd40, 32'd2, 1'b0, 1'b1, "after rst");

    // Random operations on every configuration
    for (int c = 0; c < NCFG; c++) begin
      for (int n = 0; n < 1000; n++) begin
        case ($urandom_range(0, 7))
          0:       rx = 32'hFFFF_FFFF;
          1:       rx = 32'h8000_0000 >> (32 - cfg_w(c));
          default: rx = $urandom;
        endcase
        case ($urandom_range(0, 7))
          0:       ry = rx;
          1:       ry = 32'd0;
          2:       ry = 32'd1;
          default: ry = $urandom;
        endcase
        run_op(c, 1'($urandom), rx, ry, 1'($urandom), 1'b1, $sformatf("rnd c%0d #%0d", c, n));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/addsub_seq.md
# addsub_seq

Parametrised, multi-cycle integer adder/subtractor for the MIPS datapath. It computes x ± y ± cin over WIDTH/SLICE clock cycles, SLICE bits per cycle, with a registered carry chain. Results carry borrow/carry, signed-overflow and zero flags. It sits beside the ALU as the area-reduced, width-generic successor of the single-cycle 32-bit ripple subtractor, behind valid/ready handshakes on both sides.

## Interface
- WIDTH, 32, operand/result width; must be ≥ 2 and a multiple of SLICE.
- SLICE, 8, bits processed per cycle; 1 ≤ SLICE ≤ WIDTH. NSTEP = WIDTH/SLICE.
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands (high only in IDLE).
- sub  in  1  0 = add, 1 = subtract.
- x  in  WIDTH  minuend / addend A.
- y  in  WIDTH  subtrahend / addend B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer takes result.
- z  out  WIDTH  result, two's complement modulo 2^WIDTH.
- cout  out  1  carry-out (add) or borrow-out (sub).
- ovf  out  1  signed overflow.
- zero  out  1  z == 0.

## Operation
- States are IDLE, RUN and DONE. Reset and flush force IDLE.
- IDLE: in_ready = 1. When in_valid is high:
  - latch x, latch y (or ~y if sub) and the op bit;
  - set carry register c = cin if add, ~cin if sub;
  - set slice index k = 0 and go to RUN.
- RUN: each cycle, add slice k: {c, z[k]} = xa[k] + ya[k] + c.
  - Store z slice k and increment k.
  - On the last slice (k = NSTEP−1), also capture cm = carry into bit WIDTH−1, then go to DONE.
- Arithmetic:
  - add: z = x + y + cin, cout = final carry.
  - sub: z = x − y − cin, cout = ~final carry (1 = borrow).
  - ovf = final carry XOR cm, for both ops.
  - zero = (z == 0), registered on DONE entry.
- DONE: out_valid = 1. z, cout, ovf and zero are held stable until out_valid && out_ready, then go to IDLE.
- in_ready is 0 in RUN and DONE. Operands offered then are not accepted and are ignored.
- flush has priority over every transition. From any state, at the next edge: go to IDLE, out_valid = 0, the in-flight op is discarded. A handshake coinciding with flush is not performed.
- SLICE = WIDTH: NSTEP = 1, and RUN lasts exactly one cycle.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, z 0, cout 0, ovf 0, zero 0, c 0, k 0.
- Accept at edge E0 (in_valid && in_ready). Slices are computed at edges E1..E_NSTEP. out_valid is high after E_NSTEP.
- Latency is NSTEP cycles from acceptance to out_valid.
- Minimum initiation interval is NSTEP+2 cycles, with out_ready tied high.
- in_ready and out_valid are decoded from registered state only, with no combinational path from inputs. z and the flags are registers.
- rst_n low mid-RUN or mid-DONE clears everything immediately, asynchronously. The first acceptance is possible at the first edge after rst_n rises.
- z is undefined to consumers while out_valid = 0. Partial slices may be visible during RUN.

## Test plan
- WIDTH=32, SLICE=8: sub, x=5, y=3, cin=0 -> after 4 cycles, z=0x00000002, cout=0, ovf=0, zero=0; then sub, x=3, y=5 -> z=0xFFFFFFFE, cout=1, ovf=0.
- Overflow cases:
  - sub, x=0x80000000, y=1 -> z=0x7FFFFFFF, ovf=1, cout=0.
  - add, x=0x7FFFFFFF, y=1 -> z=0x80000000, ovf=1, cout=0.
  - add, x=0xFFFFFFFF, y=1 -> z=0, cout=1, zero=1, ovf=0.
- Carry-in / borrow-in:
  - add, x=1, y=1, cin=1 -> z=3.
  - sub, x=0, y=0, cin=1 -> z=0xFFFFFFFF, cout=1.
  - Carry propagates across all slice boundaries (x=0x00FFFFFF, y=1 -> z=0x01000000).
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, z and flags are stable; in_ready stays 0 and in_valid pulses are ignored; release -> back to IDLE next edge.
- Flush at RUN slice 2 -> IDLE next edge, out_valid never rises; the next op completes correctly. Also apply rst_n low mid-RUN -> all outputs return to reset values immediately.
- Parameter sweep: (WIDTH, SLICE) = (32,1), (32,32), (16,4), (8,8). Run 1000 random ops per configuration against a reference model; check latency = NSTEP and all flags.
